issue_scheduler: RTL and testbench
==================================

ISSUE_SCHEDULER -- requirements
Module: issue_scheduler

Interface
REQ-001: The block SHALL have one parameter, NUM_WARPS, default 8, giving the number of warps arbitrated; all per-warp buses are NUM_WARPS wide and the warp index is log2(NUM_WARPS) bits.
REQ-002: The block SHALL have port clk, input, 1 bit: the single clock, rising edge.
REQ-003: The block SHALL have port rst, input, 1 bit: the asynchronous, active-low reset.
REQ-004: The block SHALL have port Start, input, 1 bit: a single-cycle pulse that launches the warps selected by Warp_Mask.
REQ-005: The block SHALL have port Warp_Mask, input, NUM_WARPS bits: the warps to launch when Start is high.
REQ-006: The block SHALL have port IB_Valid, input, NUM_WARPS bits: the IBuffer head instruction of the warp is valid.
REQ-007: The block SHALL have port IB_Is_Mem, input, NUM_WARPS bits: the head instruction uses the memory unit (LW/SW).
REQ-008: The block SHALL have port IB_Is_Exit, input, NUM_WARPS bits: the head instruction is EXIT.
REQ-009: The block SHALL have ports Scb_Full, Scb_Dependent and Scb_Empty, input, NUM_WARPS bits each: the per-warp scoreboard status, combinational and same-cycle.
REQ-010: The block SHALL have port Mem_Busy, input, 1 bit: the memory unit cannot accept an issue this cycle.
REQ-011: The block SHALL have port Grt, output, NUM_WARPS bits: a one-hot issue grant (the per-warp RP_Grt), all-zero when nothing is issued.
REQ-012: The block SHALL have port Grt_Valid, output, 1 bit, equal to the OR of Grt.
REQ-013: The block SHALL have port Grt_WarpID, output, log2(NUM_WARPS) bits: the granted warp index, 0 when Grt_Valid is 0.
REQ-014: The block SHALL have port Warp_Active, output, NUM_WARPS bits: the warp is in state ACTIVE or DRAIN.
REQ-015: The block SHALL have port All_Done, output, 1 bit, registered: the launched kernel has fully retired.

Function
REQ-016: Each warp SHALL own a 2-bit FSM with states IDLE, ACTIVE, DRAIN and DONE.
REQ-017: On a Start pulse, any warp in IDLE or DONE with its Warp_Mask bit set SHALL move to ACTIVE on the next edge; Start SHALL have no effect on a warp in ACTIVE or DRAIN.
REQ-018: A warp in ACTIVE that is granted while its IB_Is_Exit is high SHALL move to DRAIN on the next edge.
REQ-019: A warp in DRAIN SHALL move to DONE on the first edge at which its Scb_Empty is high.
REQ-020: Eligibility of warp w SHALL be: state ACTIVE, AND IB_Valid[w], AND NOT Scb_Full[w], AND NOT Scb_Dependent[w], AND NOT (IB_Is_Mem[w] AND (Mem_Busy OR Mem_Cool)).
REQ-021: Mem_Cool SHALL be a register set to 1 on the edge following any grant with IB_Is_Mem high and cleared otherwise, limiting memory issues to at most one every 2 cycles.
REQ-022: Grt SHALL be combinational in the same cycle as eligibility, with zero-cycle latency, so that the scoreboard and IBuffer capture the entry on the same edge.
REQ-023: Arbitration SHALL be round-robin: the search starts at pointer Ptr, ascends, and wraps from NUM_WARPS-1 to 0; the first eligible warp is granted.
REQ-024: On a grant to warp w, Ptr SHALL load (w+1) mod NUM_WARPS; with no grant, Ptr SHALL hold its value.
REQ-025: A continuously eligible warp SHALL be granted within NUM_WARPS cycles.
REQ-026: At most one grant SHALL be asserted per cycle, and no grant SHALL go to a warp in IDLE, DRAIN or DONE.
REQ-027: All_Done SHALL be set on the edge at which no warp is in ACTIVE or DRAIN and at least one warp is in DONE.
REQ-028: All_Done SHALL clear on the edge following a Start pulse that launches at least one warp, and SHALL otherwise hold its value.
REQ-029: A Start pulse that coincides with a grant SHALL NOT alter that grant; newly launched warps SHALL become eligible no earlier than the following cycle.

Reset
REQ-030: While rst is low, asynchronously, all warp FSMs SHALL be IDLE, Ptr SHALL be 0, Mem_Cool SHALL be 0 and All_Done SHALL be 0, so that Grt, Grt_Valid, Grt_WarpID and Warp_Active are all 0.
REQ-031: A reset asserted mid-operation SHALL abandon all state immediately, with no drain; after release, no grant SHALL occur until the next Start pulse.

Verification
REQ-032: The bench SHALL cover: Start with Warp_Mask=8'hFF, all IB_Valid high, no hazards -> grants go to warps 0,1,...,7,0 on consecutive cycles, Ptr wraps from 7 to 0.
REQ-033: The bench SHALL cover: warps 2 and 5 eligible, Ptr=3 -> warp 5 is granted, then warp 2 on the next cycle, with Grt_WarpID=5 then 2.
REQ-034: The bench SHALL cover: warps 0 and 1 both issuing memory instructions with Mem_Busy=0 -> grant to warp 0, then no memory grant for one cycle (Mem_Cool), then grant to warp 1.
REQ-035: The bench SHALL cover: Scb_Dependent[3]=1 with only warp 3 ready -> Grt=0; when Scb_Dependent[3] drops, Grt=8'h08 in the same cycle.
REQ-036: The bench SHALL cover: warp 4 is granted an EXIT and Scb_Empty[4] rises 3 cycles later -> DRAIN for 3 cycles, then DONE; with warp 4 the only launched warp, All_Done=1 on the following edge.
REQ-037: The bench SHALL cover: rst pulled low mid-kernel with warps ACTIVE -> outputs go to 0 immediately, and after release there is no grant until Start.

Source files
------------

// File: rtl/issue_scheduler.sv
// Round-robin issue scheduler: per-warp lifecycle FSMs, a zero-latency grant
// with memory-issue throttling, and kernel-retire detection.
module issue_scheduler #(
  parameter int unsigned NUM_WARPS = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         Start,
  input  logic [NUM_WARPS-1:0]         Warp_Mask,
  input  logic [NUM_WARPS-1:0]         IB_Valid,
  input  logic [NUM_WARPS-1:0]         IB_Is_Mem,
  input  logic [NUM_WARPS-1:0]         IB_Is_Exit,
  input  logic [NUM_WARPS-1:0]         Scb_Full,
  input  logic [NUM_WARPS-1:0]         Scb_Dependent,
  input  logic [NUM_WARPS-1:0]         Scb_Empty,
  input  logic                         Mem_Busy,
  output logic [NUM_WARPS-1:0]         Grt,
  output logic                         Grt_Valid,
  output logic [$clog2(NUM_WARPS)-1:0] Grt_WarpID,
  output logic [NUM_WARPS-1:0]         Warp_Active,
  output logic                         All_Done
);

  localparam int unsigned IW = $clog2(NUM_WARPS);

  typedef enum logic [1:0] {IDLE, ACTIVE, DRAIN, DONE} warp_state_e;

  warp_state_e            state      [NUM_WARPS];
  warp_state_e            state_next [NUM_WARPS];
  logic [IW-1:0]          ptr;
  logic [IW-1:0]          ptr_next;
  logic [IW-1:0]          idx;
  logic                   found;
  logic                   mem_cool;
  logic                   launch_any;
  logic                   any_busy;
  logic                   any_done;
  logic [NUM_WARPS-1:0]   eligible;

  always_comb begin
    eligible    = '0;
    Warp_Active = '0;
    launch_any  = 1'b0;
    any_busy    = 1'b0;
    any_done    = 1'b0;
    for (int unsigned w = 0; w < NUM_WARPS; w++) begin
      eligible[w] = (state[w] == ACTIVE) && IB_Valid[w] && !Scb_Full[w] &&
                    !Scb_Dependent[w] && !(IB_Is_Mem[w] && (Mem_Busy || mem_cool));
      Warp_Active[w] = (state[w] == ACTIVE) || (state[w] == DRAIN);
      if (Start && Warp_Mask[w] && ((state[w] == IDLE) || (state[w] == DONE)))
        launch_any = 1'b1;
      if (Warp_Active[w])
        any_busy = 1'b1;
      if (state[w] == DONE)
        any_done = 1'b1;
    end
  end

  // Rotating search from ptr; the first hit wins and later hits are ignored.
  always_comb begin
    Grt        = '0;
    Grt_WarpID = '0;
    ptr_next   = ptr;
    found      = 1'b0;
    idx        = '0;
    for (int unsigned i = 0; i < NUM_WARPS; i++) begin
      idx = IW'((32'(ptr) + i) % NUM_WARPS);
      if (!found && eligible[idx]) begin
        found      = 1'b1;
        Grt[idx]   = 1'b1;
        Grt_WarpID = idx;
        ptr_next   = IW'((32'(idx) + 1) % NUM_WARPS);
      end
    end
  end

  assign Grt_Valid = |Grt;

  always_comb begin
    for (int unsigned w = 0; w < NUM_WARPS; w++) begin
      state_next[w] = state[w];
      case (state[w])
        IDLE, DONE: if (Start && Warp_Mask[w])      state_next[w] = ACTIVE;
        ACTIVE:     if (Grt[w] && IB_Is_Exit[w])    state_next[w] = DRAIN;
        DRAIN:      if (Scb_Empty[w])               state_next[w] = DONE;
        default:                                    state_next[w] = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned w = 0; w < NUM_WARPS; w++)
        state[w] <= IDLE;
      ptr      <= '0;
      mem_cool <= 1'b0;
      All_Done <= 1'b0;
    end else begin
      for (int unsigned w = 0; w < NUM_WARPS; w++)
        state[w] <= state_next[w];
      ptr      <= ptr_next;
      mem_cool <= |(Grt & IB_Is_Mem);
      // A launching Start outranks the retire condition seen in the same cycle.
      if (launch_any)
        All_Done <= 1'b0;
      else if (!any_busy && any_done)
        All_Done <= 1'b1;
    end
  end

endmodule

// File: tb/tb_issue_scheduler.sv
// Directed and random checks of issue_scheduler against a behavioural model
// of warp lifecycles, round-robin pointer and memory cool-down.
module tb_issue_scheduler;

  localparam int NW = 8;
  localparam int S_IDLE = 0, S_ACT = 1, S_DRAIN = 2, S_DONE = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          Start;
  logic [NW-1:0] Warp_Mask, IB_Valid, IB_Is_Mem, IB_Is_Exit;
  logic [NW-1:0] Scb_Full, Scb_Dependent, Scb_Empty;
  logic          Mem_Busy;
  logic [NW-1:0] Grt;
  logic          Grt_Valid;
  logic [2:0]    Grt_WarpID;
  logic [NW-1:0] Warp_Active;
  logic          All_Done;

  int compared = 0;
  int failed   = 0;

  int ms [NW];
  int mptr;
  bit mcool;
  bit mdone;

  issue_scheduler #(.NUM_WARPS(NW)) dut (
    .clk(clk), .rst(rst), .Start(Start), .Warp_Mask(Warp_Mask),
    .IB_Valid(IB_Valid), .IB_Is_Mem(IB_Is_Mem), .IB_Is_Exit(IB_Is_Exit),
    .Scb_Full(Scb_Full), .Scb_Dependent(Scb_Dependent), .Scb_Empty(Scb_Empty),
    .Mem_Busy(Mem_Busy), .Grt(Grt), .Grt_Valid(Grt_Valid),
    .Grt_WarpID(Grt_WarpID), .Warp_Active(Warp_Active), .All_Done(All_Done)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int w = 0; w < NW; w++) ms[w] = S_IDLE;
    mptr  = 0;
    mcool = 0;
    mdone = 0;
  endtask

  function automatic bit model_eligible(input int w);
    return ms[w] == S_ACT && IB_Valid[w] && !Scb_Full[w] && !Scb_Dependent[w] &&
           !(IB_Is_Mem[w] && (Mem_Busy || mcool));
  endfunction

  function automatic int model_grant();
    for (int k = 0; k < NW; k++)
      if (model_eligible((mptr + k) % NW)) return (mptr + k) % NW;
    return -1;
  endfunction

  function automatic logic [31:0] model_active();
    logic [31:0] a = '0;
    for (int w = 0; w < NW; w++)
      if (ms[w] == S_ACT || ms[w] == S_DRAIN) a[w] = 1'b1;
    return a;
  endfunction

  task automatic model_update(input int g);
    bit launch = 0, busy = 0, done = 0;
    for (int w = 0; w < NW; w++) begin
      if ((ms[w] == S_IDLE || ms[w] == S_DONE) && Start && Warp_Mask[w]) launch = 1;
      if (ms[w] == S_ACT || ms[w] == S_DRAIN) busy = 1;
      if (ms[w] == S_DONE) done = 1;
    end
    if (launch) mdone = 0;
    else if (!busy && done) mdone = 1;
    for (int w = 0; w < NW; w++) begin
      if ((ms[w] == S_IDLE || ms[w] == S_DONE) && Start && Warp_Mask[w]) ms[w] = S_ACT;
      else if (ms[w] == S_ACT && w == g && IB_Is_Exit[w]) ms[w] = S_DRAIN;
      else if (ms[w] == S_DRAIN && Scb_Empty[w]) ms[w] = S_DONE;
    end
    mcool = (g >= 0) && IB_Is_Mem[g];
    if (g >= 0) mptr = (g + 1) % NW;
  endtask

  // exp_id: -1 model only, -2 no grant required, otherwise the required warp.
  task automatic cycle(input string tag, input int exp_id);
    int g;
    @(negedge clk);
    g = model_grant();
    check({tag, ".grt"},    32'(Grt),         (g >= 0) ? (32'd1 << g) : 32'd0);
    check({tag, ".valid"},  32'(Grt_Valid),   (g >= 0) ? 32'd1 : 32'd0);
    check({tag, ".id"},     32'(Grt_WarpID),  (g >= 0) ? 32'(g) : 32'd0);
    check({tag, ".active"}, 32'(Warp_Active), model_active());
    check({tag, ".done"},   32'(All_Done),    32'(mdone));
    if (exp_id == -2)
      check({tag, ".nogrant"}, 32'(Grt), 32'd0);
    else if (exp_id >= 0)
      check({tag, ".want"}, {Grt_Valid, 28'd0, Grt_WarpID}, {1'b1, 28'd0, 3'(exp_id)});
    @(posedge clk);
    model_update(g);
    #1;
  endtask

  task automatic quiet_inputs();
    Start = 0; Warp_Mask = '0; IB_Valid = '0; IB_Is_Mem = '0; IB_Is_Exit = '0;
    Scb_Full = '0; Scb_Dependent = '0; Scb_Empty = '0; Mem_Busy = 0;
  endtask

  initial begin
    rst = 1'b0;
    quiet_inputs();
    model_reset();
    #7;
    check("reset.grt",    32'(Grt),         32'd0);
    check("reset.valid",  32'(Grt_Valid),   32'd0);
    check("reset.id",     32'(Grt_WarpID),  32'd0);
    check("reset.active", 32'(Warp_Active), 32'd0);
    check("reset.done",   32'(All_Done),    32'd0);
    @(posedge clk); #1;
    rst = 1'b1;

    // All warps launched and ready: strict 0..7 rotation and wrap back to 0.
    Start = 1; Warp_Mask = 8'hFF; IB_Valid = 8'hFF;
    cycle("launch", -2);
    Start = 0; Warp_Mask = '0;
    for (int i = 0; i <= NW; i++) cycle("rr", i % NW);

    // Steer ptr to 3, then warps 2 and 5 ready.
    IB_Valid = 8'h04;
    cycle("steer", 2);
    IB_Valid = 8'h24;
    cycle("p3a", 5);
    cycle("p3b", 2);

    // Dependency blocks the only ready warp; grant appears as it drops.
    IB_Valid = 8'h08; Scb_Dependent = 8'h08;
    cycle("dep", -2);
    Scb_Dependent = '0;
    cycle("deprel", 3);

    // Back-to-back memory instructions are spaced by the cool-down cycle.
    IB_Valid = 8'h03; IB_Is_Mem = 8'h03;
    cycle("mem0", 0);
    cycle("memcool", -2);
    cycle("mem1", 1);
    Mem_Busy = 1;
    cycle("membusy", -2);
    quiet_inputs();

    for (int n = 0; n < 400; n++) begin
      Start         = ($urandom_range(0, 15) == 0);
      Warp_Mask     = 8'($urandom);
      IB_Valid      = 8'($urandom | $urandom);
      IB_Is_Mem     = 8'($urandom);
      IB_Is_Exit    = 8'($urandom & $urandom & $urandom);
      Scb_Full      = 8'($urandom & $urandom & $urandom);
      Scb_Dependent = 8'($urandom & $urandom);
      Scb_Empty     = 8'($urandom);
      Mem_Busy      = ($urandom_range(0, 3) == 0);
      cycle("rand", -1);
    end
    quiet_inputs();

    // Asynchronous reset mid-kernel, then silence until the next Start.
    Start = 1; Warp_Mask = 8'hFF; IB_Valid = 8'hFF;
    cycle("prerst", -1);
    Start = 0; Warp_Mask = '0;
    cycle("prerst2", -1);
    #2 rst = 1'b0;
    #1;
    check("arst.grt",    32'(Grt),         32'd0);
    check("arst.valid",  32'(Grt_Valid),   32'd0);
    check("arst.id",     32'(Grt_WarpID),  32'd0);
    check("arst.active", 32'(Warp_Active), 32'd0);
    check("arst.done",   32'(All_Done),    32'd0);
    model_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    for (int i = 0; i < 3; i++) cycle("postrst", -2);

    // Lone warp 4 exits, drains for 3 cycles, then the kernel retires.
    Start = 1; Warp_Mask = 8'h10; IB_Valid = 8'h10; IB_Is_Exit = 8'h10;
    cycle("w4launch", -2);
    Start = 0; Warp_Mask = '0;
    cycle("w4exit", 4);
    IB_Valid = '0; IB_Is_Exit = '0;
    cycle("drain1", -2);
    check("drain.active", 32'(Warp_Active), 32'h10);
    cycle("drain2", -2);
    Scb_Empty = 8'h10;
    cycle("drain3", -2);
    check("done.active", 32'(Warp_Active), 32'h0);
    check("done.notyet", 32'(All_Done),    32'h0);
    Scb_Empty = '0;
    cycle("retire", -2);
    check("alldone.set", 32'(All_Done), 32'h1);
    cycle("hold", -2);
    check("alldone.hold", 32'(All_Done), 32'h1);
    Start = 1; Warp_Mask = 8'h10;
    cycle("relaunch", -2);
    Start = 0; Warp_Mask = '0;
    check("alldone.clr", 32'(All_Done), 32'h0);
    cycle("after", -2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
    $finish;
  end

endmodule
